// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, redirect/halt control, decode handshake.
// Optional perf counters enabled with macro FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [9:0] RESET_PC = 10'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  imem_addr,
  input  logic [15:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [9:0]  redirect_pc,
  input  logic        halt_req,
  input  logic        dec_ready,
  output logic        dec_valid,
  output logic [15:0] dec_instr,
  output logic [9:0]  dec_pc,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] perf_fetch_cnt,
  output logic [15:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_pc;
  logic [9:0]  w_pc_nxt;
  logic        r_dv;
  logic        w_dv_nxt;
  logic [15:0] r_instr;
  logic [15:0] w_instr_nxt;
  logic [9:0]  r_dpc;
  logic [9:0]  w_dpc_nxt;
  logic        w_fetch;
  logic        w_stall;

  assign w_stall = r_dv && !dec_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_dv    <= 1'b0;
      r_instr <= 16'h0000;
      r_dpc   <= 10'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_dv    <= w_dv_nxt;
      r_instr <= w_instr_nxt;
      r_dpc   <= w_dpc_nxt;
    end
  end

  // Priority in RUN: redirect, then stall hold, then halt, then fetch.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_dv_nxt    = r_dv;
    w_instr_nxt = r_instr;
    w_dpc_nxt   = r_dpc;
    w_fetch     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (redirect_valid) begin
          w_pc_nxt = redirect_pc;
          w_dv_nxt = 1'b0;
        end else if (w_stall) begin
          w_dv_nxt = 1'b1;
        end else if (halt_req) begin
          w_dv_nxt    = 1'b0;
          w_state_nxt = S_HALT;
        end else begin
          w_fetch     = 1'b1;
          w_instr_nxt = imem_instr;
          w_dpc_nxt   = r_pc;
          w_dv_nxt    = 1'b1;
          w_pc_nxt    = r_pc + 10'd1;
        end
      end
      S_HALT: begin
        w_dv_nxt = 1'b0;
        if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_dv_nxt    = 1'b0;
      end
    endcase
  end

  assign imem_addr = r_pc;
  assign dec_valid = r_dv;
  assign dec_instr = r_instr;
  assign dec_pc    = r_dpc;
  assign halted    = (r_state == S_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_fetch_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= 16'h0000;
      r_stall_cnt <= 16'h0000;
    end else begin
      if (w_fetch && (r_fetch_cnt != 16'hFFFF))
        r_fetch_cnt <= r_fetch_cnt + 16'd1;
      if (w_stall && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Memory returns {~addr[5:0], addr} for each word address.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [9:0]  imem_addr;
  logic [15:0] imem_instr;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        halt_req;
  logic        dec_ready;
  logic        dec_valid;
  logic [15:0] dec_instr;
  logic [9:0]  dec_pc;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  int n_cmp;
  int n_bad;

  function automatic logic [15:0] instr_of(input logic [9:0] a);
    return {~a[5:0], a};
  endfunction

  assign imem_instr = instr_of(imem_addr);

  fetch_unit #(.RESET_PC(10'd0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .dec_ready      (dec_ready),
    .dec_valid      (dec_valid),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves DUT in RUN with pc=0, nothing valid yet.
  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 10'd0;
    halt_req = 1'b0;
    dec_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [27:0] obs;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 10'd0;
    halt_req = 1'b0;
    dec_ready = 1'b1;
    tick();
    tick();
    obs = {dec_valid, halted, dec_pc, dec_instr};
    n_cmp++;
    if (obs !== 28'h0) begin
      n_bad++;
      $display("FAIL reset_state got %h want 0", obs);
    end
    n_cmp++;
    if (imem_addr !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_pc got %0d want 0", imem_addr);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (dec_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_cyc1_valid got %b want 0", dec_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({dec_valid, dec_pc, dec_instr} !==
          {1'b1, 10'(i), instr_of(10'(i))}) begin
        n_bad++;
        $display("FAIL reset_seq%0d got v=%b pc=%0d i=%h want pc=%0d i=%h",
                 i, dec_valid, dec_pc, dec_instr, i, instr_of(10'(i)));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    n_cmp++;
    if ({dec_valid, dec_pc} !== {1'b1, 10'd5}) begin
      n_bad++;
      $display("FAIL stall_pre got pc=%0d want 5", dec_pc);
    end
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({dec_valid, dec_pc, dec_instr, imem_addr} !==
          {1'b1, 10'd5, instr_of(10'd5), 10'd6}) begin
        n_bad++;
        $display("FAIL stall_hold%0d got v=%b pc=%0d i=%h a=%0d want 5/6",
                 i, dec_valid, dec_pc, dec_instr, imem_addr);
      end
    end
    dec_ready = 1'b1;
    tick();
    n_cmp++;
    if ({dec_valid, dec_pc, dec_instr} !== {1'b1, 10'd6, instr_of(10'd6)}) begin
      n_bad++;
      $display("FAIL stall_release got pc=%0d want 6", dec_pc);
    end
`ifdef FETCH_PERF_CNT_EN
    n_cmp++;
    if (perf_stall_cnt !== 16'd3) begin
      n_bad++;
      $display("FAIL perf_stall got %0d want 3", perf_stall_cnt);
    end
    n_cmp++;
    if (perf_fetch_cnt !== 16'd7) begin
      n_bad++;
      $display("FAIL perf_fetch got %0d want 7", perf_fetch_cnt);
    end
`endif
  endtask

  task automatic test_redirect();
    do_reset();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 10'd3;
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if (dec_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL redir_bubble got v=%b want 0", dec_valid);
    end
    tick();
    n_cmp++;
    if ({dec_valid, dec_pc, dec_instr} !== {1'b1, 10'd3, instr_of(10'd3)}) begin
      n_bad++;
      $display("FAIL redir_target got v=%b pc=%0d want 3", dec_valid, dec_pc);
    end
    dec_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 10'd9;
    tick();
    redirect_valid = 1'b0;
    dec_ready = 1'b1;
    n_cmp++;
    if ({dec_valid, imem_addr} !== {1'b0, 10'd9}) begin
      n_bad++;
      $display("FAIL redir_stalled got v=%b a=%0d want 0/9", dec_valid, imem_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 10'd1022;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({dec_valid, dec_pc, dec_instr} !==
          {1'b1, 10'(1022 + i), instr_of(10'(1022 + i))}) begin
        n_bad++;
        $display("FAIL wrap%0d got v=%b pc=%0d want %0d",
                 i, dec_valid, dec_pc, (1022 + i) % 1024);
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    tick();
    tick();
    dec_ready = 1'b0;
    halt_req = 1'b1;
    tick();
    n_cmp++;
    if ({dec_valid, halted, dec_pc} !== {1'b1, 1'b0, 10'd1}) begin
      n_bad++;
      $display("FAIL halt_held got v=%b h=%b pc=%0d want 1/0/1",
               dec_valid, halted, dec_pc);
    end
    dec_ready = 1'b1;
    tick();
    n_cmp++;
    if ({dec_valid, halted} !== 2'b01) begin
      n_bad++;
      $display("FAIL halt_enter got v=%b h=%b want 0/1", dec_valid, halted);
    end
    halt_req = 1'b0;
    tick();
    n_cmp++;
    if ({dec_valid, halted, imem_addr} !== {2'b01, 10'd2}) begin
      n_bad++;
      $display("FAIL halt_stay got v=%b h=%b a=%0d want 0/1/2",
               dec_valid, halted, imem_addr);
    end
    redirect_valid = 1'b1;
    redirect_pc = 10'd2;
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if ({dec_valid, halted} !== 2'b00) begin
      n_bad++;
      $display("FAIL halt_exit got v=%b h=%b want 0/0", dec_valid, halted);
    end
    tick();
    n_cmp++;
    if ({dec_valid, dec_pc, dec_instr} !== {1'b1, 10'd2, instr_of(10'd2)}) begin
      n_bad++;
      $display("FAIL halt_resume got v=%b pc=%0d want 2", dec_valid, dec_pc);
    end
  endtask

  task automatic test_redirect_halt();
    do_reset();
    tick();
    redirect_valid = 1'b1;
    halt_req = 1'b1;
    redirect_pc = 10'd7;
    tick();
    redirect_valid = 1'b0;
    halt_req = 1'b0;
    n_cmp++;
    if ({dec_valid, halted} !== 2'b00) begin
      n_bad++;
      $display("FAIL both_cyc1 got v=%b h=%b want 0/0", dec_valid, halted);
    end
    tick();
    n_cmp++;
    if ({dec_valid, halted, dec_pc} !== {2'b10, 10'd7}) begin
      n_bad++;
      $display("FAIL both_target got v=%b h=%b pc=%0d want 1/0/7",
               dec_valid, halted, dec_pc);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    tick();
    tick();
    dec_ready = 1'b0;
    tick();
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 10'd50;
    halt_req = 1'b1;
    tick();
    n_cmp++;
    if ({dec_valid, halted, dec_pc, dec_instr, imem_addr} !== 38'h0) begin
      n_bad++;
      $display("FAIL rst_midstall got v=%b h=%b pc=%0d i=%h a=%0d want 0",
               dec_valid, halted, dec_pc, dec_instr, imem_addr);
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
    halt_req = 1'b0;
    dec_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({dec_valid, dec_pc} !== {1'b1, 10'd0}) begin
      n_bad++;
      $display("FAIL rst_restart got v=%b pc=%0d want 1/0", dec_valid, dec_pc);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 10'd0;
    halt_req = 1'b0;
    dec_ready = 1'b1;
    test_reset();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_redirect_halt();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 10'd0, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-004 SHALL have port imem_addr, output, 10, word address to instruction memory.
REQ-005 SHALL have port imem_instr, input, 16, instruction word returned combinationally for imem_addr.
REQ-006 SHALL have port redirect_valid, input, 1, branch/jump taken request from execute.
REQ-007 SHALL have port redirect_pc, input, 10, target word address for a redirect.
REQ-008 SHALL have port halt_req, input, 1, request to stop fetching.
REQ-009 SHALL have port dec_ready, input, 1, decode stage can accept an instruction this cycle.
REQ-010 SHALL have port dec_valid, output, 1, dec_instr/dec_pc hold a valid instruction.
REQ-011 SHALL have port dec_instr, output, 16, fetched instruction to decode.
REQ-012 SHALL have port dec_pc, output, 10, address dec_instr was fetched from.
REQ-013 SHALL have port halted, output, 1, high while in HALT state.

Function
REQ-014 SHALL implement states IDLE, RUN, HALT; IDLE -> RUN unconditionally on the next cycle.
REQ-015 SHALL drive imem_addr combinationally from the internal pc register.
REQ-016 SHALL, in RUN with (!dec_valid || dec_ready) and no redirect/halt, load dec_instr<=imem_instr, dec_pc<=pc, dec_valid<=1, pc<=pc+1.
REQ-017 SHALL wrap pc from 10'd1023 to 10'd0 with no flag or stall.
REQ-018 SHALL, while dec_valid && !dec_ready, hold pc, dec_instr, dec_pc and dec_valid unchanged.
REQ-019 SHALL, in RUN with dec_ready=1 and no new fetch possible, clear dec_valid after the handshake.
REQ-020 SHALL give redirect_valid highest priority in any non-IDLE state: pc<=redirect_pc, dec_valid<=0 next cycle regardless of dec_ready.
REQ-021 SHALL present the instruction at redirect_pc with dec_valid=1 exactly two cycles after the redirect cycle, given dec_ready=1.
REQ-022 SHALL, on halt_req in RUN without redirect, stop advancing pc and enter HALT once dec_valid=0 or the held instruction is accepted.
REQ-023 SHALL ignore halt_req in a cycle where redirect_valid=1.
REQ-024 SHALL, in HALT, keep dec_valid=0, halted=1, and return to RUN only on redirect_valid, taking redirect_pc as the new pc.

Reset
REQ-025 SHALL on rst=1 set state=IDLE, pc=RESET_PC, dec_valid=0, dec_instr=16'h0000, dec_pc=10'd0, halted=0.
REQ-026 SHALL give rst priority over redirect_valid, halt_req and any in-flight handshake, including mid-stall.
REQ-027 SHALL produce first dec_valid=1 (instruction at RESET_PC) two cycles after rst deasserts.

Configuration
REQ-028 SHALL, with macro FETCH_PERF_CNT_EN defined, add outputs perf_fetch_cnt (16) counting REQ-016 loads and perf_stall_cnt (16) counting dec_valid && !dec_ready cycles, both saturating at 16'hFFFF and reset to 0.
REQ-029 SHALL, without FETCH_PERF_CNT_EN, omit both ports and counter logic; all other behaviour identical.

Verification
REQ-030 SHALL test reset release with dec_ready=1 held -> dec_pc sequence 0,1,2,3 on consecutive cycles from cycle 2, dec_instr matching memory.
REQ-031 SHALL test dec_ready=0 for 3 cycles at dec_pc=5 -> outputs frozen at pc 5, then pc 6 the cycle after dec_ready=1 (perf_stall_cnt=3 when macro defined).
REQ-032 SHALL test redirect_valid with redirect_pc=10'd3 at dec_pc=1 -> dec_valid=0 next cycle, dec_pc=3 valid the cycle after.
REQ-033 SHALL test pc=1023 with dec_ready=1 -> dec_pc 1023 followed by dec_pc 0.
REQ-034 SHALL test halt_req with a stalled instruction -> HALT entered only after acceptance, halted=1; redirect_pc=10'd2 -> RUN, dec_pc=2.
REQ-035 SHALL test simultaneous redirect_valid and halt_req -> redirect taken, halted stays 0.
